// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants and records for the sprite pipeline.
// OAM word layout, attribute bits, sizing defaults, slot record, FSM states.
package gpu_pkg;

  localparam int NUM_SPRITES_DEF = 64;
  localparam int MAX_SLOTS_DEF   = 8;
  localparam int SPRITE_H_DEF    = 8;

  localparam int Y_MSB    = 31;
  localparam int X_MSB    = 23;
  localparam int TILE_MSB = 15;
  localparam int ATTR_MSB = 7;

  localparam int ATTR_VFLIP = 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } eval_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [2:0] row;
  } slot_t;

endpackage

// File: rtl/sprite_line_eval_if.sv
// sprite_line_eval_if: OAM read bus plus the front-bank slot read port.
// master = evaluator side (drives oam_addr, slot_*), slave = OAM/compositor.
interface sprite_line_eval_if
  import gpu_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int MAX_SLOTS   = MAX_SLOTS_DEF
);
  localparam int AW = $clog2(NUM_SPRITES);
  localparam int IW = $clog2(MAX_SLOTS);

  logic [AW-1:0] oam_addr;
  logic [31:0]   oam_data;
  logic [IW-1:0] slot_idx;
  logic          slot_valid;
  logic [7:0]    slot_x;
  logic [7:0]    slot_tile;
  logic [7:0]    slot_attr;
  logic [2:0]    slot_row;

  modport master (
    output oam_addr,
    input  oam_data,
    input  slot_idx,
    output slot_valid,
    output slot_x,
    output slot_tile,
    output slot_attr,
    output slot_row
  );

  modport slave (
    input  oam_addr,
    output oam_data,
    output slot_idx,
    input  slot_valid,
    input  slot_x,
    input  slot_tile,
    input  slot_attr,
    input  slot_row
  );

endinterface

// File: rtl/sprite_slot_bank.sv
// sprite_slot_bank: MAX_SLOTS-entry slot register file.
// Ports: clear-all, indexed write (we/waddr/wdata), combinational read.
module sprite_slot_bank
  import gpu_pkg::*;
#(
  parameter int MAX_SLOTS = MAX_SLOTS_DEF,
  localparam int IW = $clog2(MAX_SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  slot_t         wdata,
  input  logic [IW-1:0] raddr,
  output slot_t         rdata
);

  slot_t mem [MAX_SLOTS];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < MAX_SLOTS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_line_eval.sv
// sprite_line_eval: scans OAM during hblank, fills the back slot bank.
// Ports: clk/rst, eval_start/eval_y, bus (OAM + slot read), busy/done/overflow/eval_overrun.
module sprite_line_eval
  import gpu_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int MAX_SLOTS   = MAX_SLOTS_DEF,
  parameter int SPRITE_H    = SPRITE_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eval_start,
  input  logic [7:0]         eval_y,
  sprite_line_eval_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               eval_overrun
);

  localparam int AW = $clog2(NUM_SPRITES);
  localparam int IW = $clog2(MAX_SLOTS);
  localparam int CW = IW + 1;
  localparam logic [AW-1:0] LAST = AW'(NUM_SPRITES - 1);

  eval_state_t state, state_nx;

  logic [AW-1:0] addr;
  logic [7:0]    y_q;
  logic          rd_vld;
  logic [CW-1:0] cnt;
  logic          ovf_pend;
  logic          bank_sel;

  logic [7:0] o_y, o_x, o_tile, o_attr;
  logic [7:0] diff;
  logic [2:0] row;
  logic       hit, full, wr;
  slot_t      wdata, rd0, rd1, front;

  assign o_y    = bus.oam_data[Y_MSB -: 8];
  assign o_x    = bus.oam_data[X_MSB -: 8];
  assign o_tile = bus.oam_data[TILE_MSB -: 8];
  assign o_attr = bus.oam_data[ATTR_MSB -: 8];

  // Wrapping distance lets sprites near y=255 reach the top lines.
  assign diff = y_q - o_y;
  // The datum in flight at a restart belongs to the abandoned scan.
  assign hit  = rd_vld && !eval_start && (diff < 8'(SPRITE_H));
  assign full = (cnt == CW'(MAX_SLOTS));
  assign wr   = hit && !full;
  assign row  = o_attr[ATTR_VFLIP] ? 3'(SPRITE_H - 1) - diff[2:0]
                                   : diff[2:0];

  assign wdata = '{valid: 1'b1, x: o_x, tile: o_tile,
                   attr: o_attr, row: row};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = IDLE;
      SCAN:    if (addr == LAST) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (eval_start) state_nx = SCAN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      y_q      <= '0;
      rd_vld   <= 1'b0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bank_sel <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= (state == SCAN) && !eval_start;
      if (eval_start) begin
        bank_sel <= ~bank_sel;
        y_q      <= eval_y;
        cnt      <= '0;
        ovf_pend <= 1'b0;
        addr     <= '0;
      end else begin
        if (state == SCAN) addr <= addr + 1'b1;
        if (wr) cnt <= cnt + 1'b1;
        if (hit && full) ovf_pend <= 1'b1;
        if (state == DRAIN) begin
          done     <= 1'b1;
          overflow <= ovf_pend || (hit && full);
        end
      end
    end
  end

  // bank_sel picks the front bank; the other one is being filled.
  sprite_slot_bank #(.MAX_SLOTS(MAX_SLOTS)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .clear (eval_start && !bank_sel),
    .we    (wr && bank_sel),
    .waddr (cnt[IW-1:0]),
    .wdata (wdata),
    .raddr (bus.slot_idx),
    .rdata (rd0)
  );

  sprite_slot_bank #(.MAX_SLOTS(MAX_SLOTS)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .clear (eval_start && bank_sel),
    .we    (wr && !bank_sel),
    .waddr (cnt[IW-1:0]),
    .wdata (wdata),
    .raddr (bus.slot_idx),
    .rdata (rd1)
  );

  assign front = bank_sel ? rd1 : rd0;

  assign bus.oam_addr   = addr;
  assign bus.slot_valid = front.valid;
  assign bus.slot_x     = front.x;
  assign bus.slot_tile  = front.tile;
  assign bus.slot_attr  = front.attr;
  assign bus.slot_row   = front.row;

  assign busy         = (state != IDLE);
  assign eval_overrun = eval_start && busy && !rst;

endmodule

// File: doc/sprite_line_eval.md
Name: sprite_line_eval

Overview:
- Sprite evaluation stage directly downstream of the video timing generator.
- Uses each horizontal-blank interval to scan OAM for sprites that intersect the next scanline.
- Fills up to MAX_SLOTS slot registers in a double-buffered slot table.
- The pixel compositor reads the front bank during the following visible line, indexed by xp.

Parameters:
- NUM_SPRITES, 64: OAM entries scanned per line; power of two.
- MAX_SLOTS, 8: sprites retained per line; power of two.
- SPRITE_H, 8: sprite height in lines.

Ports:
- clk  in  1  pixel clock (12.5875 MHz)
- rst  in  1  synchronous, active-high reset
- eval_start  in  1  one-cycle pulse on the visible-to-blank edge of each line.
- eval_y  in  8  target scanline; sampled on eval_start.
- oam_addr  out  log2(NUM_SPRITES)  OAM read address.
- oam_data  in  32  OAM word: [31:24] y, [23:16] x, [15:8] tile, [7:0] attr. Synchronous RAM, data valid 1 cycle after address.
- slot_idx  in  log2(MAX_SLOTS)  front-bank read index (combinational read).
- slot_valid  out  1  front slot occupied.
- slot_x  out  8  sprite x.
- slot_tile  out  8  tile index.
- slot_attr  out  8  attributes, passed through unmodified.
- slot_row  out  3  row within the tile, vflip already applied.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan completes.
- overflow  out  1  more than MAX_SLOTS hits on the last completed scan; held until the next done.
- eval_overrun  out  1  one-cycle pulse when eval_start arrives while busy.

Behaviour:
- Reset values: both banks slot_valid=0; state IDLE; oam_addr=0; busy=0, done=0, overflow=0, eval_overrun=0; front bank = bank 0.
- States: IDLE, SCAN, DRAIN.
- eval_start in any state:
  - Swap front/back banks.
  - Clear all valid bits of the new back bank.
  - Latch eval_y; reset hit count to 0.
  - Set oam_addr=0, go to SCAN, busy=1.
- SCAN:
  - oam_addr increments by 1 every cycle.
  - At oam_addr = NUM_SPRITES-1, go to DRAIN next cycle.
- DRAIN: one cycle to consume the last read datum, then done=1, busy=0, go to IDLE.
- Timing: total scan = NUM_SPRITES+2 cycles (66 at the defaults), within the 80-cycle hblank.
- Hit test, on each returned datum (one cycle after its address):
  - diff = (eval_y - y) mod 256, 8-bit wrapping.
  - Hit iff diff < SPRITE_H.
  - Sprites with y near 255 therefore wrap onto lines 0..6.
- On a hit with count < MAX_SLOTS:
  - Write x, tile and attr to back slot[count]; set valid; count++.
  - Row = attr[1] (vflip) ? SPRITE_H-1-diff : diff, truncated to 3 bits.
- On a hit with count = MAX_SLOTS: set the pending overflow flag; no write.
- Priority: lower OAM index wins the lower slot.
- overflow output updates only at done.
- eval_start while busy:
  - eval_overrun=1 for that cycle.
  - The partially filled back bank becomes front, unchanged.
  - A new scan restarts; the pending overflow flag is discarded.
- The front bank is never written during a scan; the read port is stable for the whole line.
- rst mid-scan: immediate return to IDLE and the reset values above.

Decomposition:
- Package gpu_pkg holds:
  - OAM field offsets (Y_MSB, X_MSB, TILE_MSB, ATTR_MSB).
  - ATTR_VFLIP=1.
  - NUM_SPRITES, MAX_SLOTS, SPRITE_H defaults.
  - slot record typedef: valid, x, tile, attr, row.
- One sub-module, sprite_slot_bank: MAX_SLOTS-entry register file with clear-all, indexed write port and combinational read port; instantiated twice.

Test Plan:
- Hit test and vflip:
  - Stimulus: OAM[3].y=10, OAM[40].y=12 with attr[1]=1; eval_start with eval_y=14.
  - Response: slot0 = sprite 3, row 4; slot1 = sprite 40, row 5; slot2 valid=0; done exactly 66 cycles after eval_start; overflow=0.
- Overflow:
  - Stimulus: 10 sprites with y=20; eval_y=22.
  - Response: slots 0..7 are the 8 lowest OAM indices, all row 2; overflow=1 at done.
  - Follow-up: rescan with no hits -> overflow returns to 0.
- Wrap-around:
  - Stimulus: sprite y=254; eval_y=3, then eval_y=5.
  - Response: eval_y=3 -> hit, row 5; eval_y=5 -> diff=7, hit, row 7.
  - Follow-up: eval_y=6 -> no hit.
- Overrun:
  - Stimulus: second eval_start 30 cycles into a scan.
  - Response: eval_overrun pulses once; front shows only hits from OAM 0..27; new scan completes normally.
- Bank stability and reset:
  - Stimulus: read all slot_idx values continuously during a scan.
  - Response: outputs unchanged until the next eval_start.
  - Stimulus: assert rst mid-scan.
  - Response: busy=0, all slot_valid=0, oam_addr=0 on the following cycle.
